// File: rtl/fir1_decim2_if.sv
// Sample stream bundle for fir1_decim2.
//   in_valid  : in_data is taken on a rising clk edge while high
//   in_data   : 14-bit signed input sample
//   out_valid : one-cycle strobe marking a new out_data
//   out_data  : 14-bit signed decimated sample, held between strobes
// master = sample source / result sink, slave = the filter.
interface fir1_decim2_if;
   logic               in_valid;
   logic signed [13:0] in_data;
   logic               out_valid;
   logic signed [13:0] out_data;

   modport master (output in_valid, output in_data, input out_valid, input out_data);
   modport slave  (input in_valid, input in_data, output out_valid, output out_data);
endinterface

// File: rtl/fir1_decim2.sv
// Half-band decimate-by-2 FIR, 23 taps, receive direction.
// Produces one rounded, saturated 14-bit output for every two accepted
// input samples. Streaming, no backpressure, fixed latency of 3 cycles
// from the triggering sample to out_valid.
//   clk   : sample-processing clock
//   reset : asynchronous, active-high
//   io    : fir1_decim2_if.slave (in_valid/in_data in, out_valid/out_data out)
module fir1_decim2 (
   input  logic               clk,
   input  logic               reset,
   fir1_decim2_if.slave       io
);

   // Non-zero taps of the symmetric response; h[k] == h[22-k].
   localparam logic signed [31:0] H0  = -32'sd12;
   localparam logic signed [31:0] H2  =  32'sd84;
   localparam logic signed [31:0] H4  = -32'sd337;
   localparam logic signed [31:0] H6  =  32'sd1008;
   localparam logic signed [31:0] H8  = -32'sd2693;
   localparam logic signed [31:0] H10 =  32'sd10142;
   localparam logic signed [31:0] H11 =  32'sd16384;

   logic [22:0][13:0]  x_q;        // x_q[0] is the newest sample
   logic               phase_q;
   logic               accept;

   logic               v0_q, v1_q, v2_q;
   logic signed [14:0] p0_q, p2_q, p4_q, p6_q, p8_q, p10_q;
   logic signed [13:0] c_q;
   logic signed [31:0] acc_q;
   logic signed [31:0] mac;
   logic signed [16:0] r;
   logic signed [13:0] sat;

   logic               out_valid_q;
   logic signed [13:0] out_data_q;

   assign accept = io.in_valid;

   always_comb begin
      mac = 32'(p0_q) * H0 + 32'(p2_q) * H2 + 32'(p4_q) * H4
          + 32'(p6_q) * H6 + 32'(p8_q) * H8 + 32'(p10_q) * H10
          + 32'(c_q) * H11;
   end

   // Round half up, then clamp to the 14-bit output range.
   always_comb begin
      r = 17'((acc_q + 32'sd16384) >>> 15);
      if (r > 17'sd8191)
         sat = 14'sd8191;
      else if (r < -17'sd8192)
         sat = -14'sd8192;
      else
         sat = r[13:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q         <= '0;
         phase_q     <= 1'b0;
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         p0_q        <= '0;
         p2_q        <= '0;
         p4_q        <= '0;
         p6_q        <= '0;
         p8_q        <= '0;
         p10_q       <= '0;
         c_q         <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         // The sample that arrives with phase=1 completes a pair and
         // launches a computation on the line after it has shifted in.
         v0_q <= accept & phase_q;
         if (accept) begin
            x_q     <= {x_q[21:0], io.in_data};
            phase_q <= ~phase_q;
         end

         v1_q <= v0_q;
         if (v0_q) begin
            p0_q  <= {x_q[0][13],  x_q[0]}  + {x_q[22][13], x_q[22]};
            p2_q  <= {x_q[2][13],  x_q[2]}  + {x_q[20][13], x_q[20]};
            p4_q  <= {x_q[4][13],  x_q[4]}  + {x_q[18][13], x_q[18]};
            p6_q  <= {x_q[6][13],  x_q[6]}  + {x_q[16][13], x_q[16]};
            p8_q  <= {x_q[8][13],  x_q[8]}  + {x_q[14][13], x_q[14]};
            p10_q <= {x_q[10][13], x_q[10]} + {x_q[12][13], x_q[12]};
            c_q   <= x_q[11];
         end

         v2_q <= v1_q;
         if (v1_q)
            acc_q <= mac;

         out_valid_q <= v2_q;
         if (v2_q)
            out_data_q <= sat;
      end
   end

   assign io.out_valid = out_valid_q;
   assign io.out_data  = out_data_q;

endmodule

// File: tb/tb_fir1_decim2.sv
module tb_fir1_decim2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fir1_decim2_if dif ();

   fir1_decim2 dut (
      .clk   (clk),
      .reset (reset),
      .io    (dif.slave)
   );

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   typedef struct {
      int val;
      int due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      bit rst;
      bit vld;
      int din;
      bit has_exp;
      int exp;
   } vec_t;
   vec_t vecs[$];

   int h[23] = '{-12, 0, 84, 0, -337, 0, 1008, 0, -2693, 0, 10142, 16384,
                  10142, 0, -2693, 0, 1008, 0, -337, 0, 84, 0, -12};
   int odd_exp[12] = '{-3, 21, -84, 252, -673, 2535, 2535, -673, 252, -84, 21, -3};

   int hist[23];
   bit ph;
   int last_exp = 0;
   int strobes = 0;
   bit prev_valid = 1'b0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
      end
   endtask

   // Direct 23-tap reference convolution on the current window.
   function automatic int model_out();
      int acc;
      int rr;
      acc = 0;
      for (int k = 0; k < 23; k++) acc += h[k] * hist[k];
      rr = (acc + 16384) >>> 15;
      if (rr > 8191) rr = 8191;
      if (rr < -8192) rr = -8192;
      return rr;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 23; k++) hist[k] = 0;
      ph = 1'b0;
      sb.delete();
      last_exp = 0;
   endtask

   task automatic apply(input bit v, input int din, input bit has_exp, input int exp);
      int val;
      dif.in_valid = v;
      dif.in_data  = din[13:0];
      @(posedge clk);
      #1;
      if (v) begin
         for (int k = 22; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = din;
         if (ph) begin
            val = has_exp ? exp : model_out();
            sb.push_back('{val, edge_n + 3});
         end
         ph = ~ph;
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      model_clear();
      repeat (n) begin
         dif.in_valid = 1'($urandom_range(0, 1));
         dif.in_data  = 14'($urandom);
         @(negedge clk);
         check("reset_out_valid", int'(dif.out_valid), 0);
         check("reset_out_data", int'(dif.out_data), 0);
      end
      @(posedge clk);
      #1;
      dif.in_valid = 1'b0;
      dif.in_data  = '0;
      reset = 1'b0;
   endtask

   // Output monitor: scoreboard pop, latency, hold and spacing checks.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (dif.out_valid) begin
            strobes++;
            if (sb.size() == 0) begin
               check("spurious_out_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("out_data", int'(dif.out_data), e.val);
               check("out_latency", edge_n, e.due);
               last_exp = e.val;
            end
            if (prev_valid) check("out_valid_back_to_back", 1, 0);
         end else begin
            check("out_data_hold", int'(dif.out_data), last_exp);
         end
      end
      prev_valid = dif.out_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      int s0;
      dif.in_valid = 1'b0;
      dif.in_data  = '0;

      // Odd-index impulse.
      for (int i = 0; i < 26; i++)
         vecs.push_back('{i == 0, 1'b1, (i == 1) ? 8191 : 0, i[0],
                          (i[0] && (i - 1) / 2 < 12) ? odd_exp[(i - 1) / 2] : 0});
      // Even-index impulse: only the centre tap sees it.
      for (int i = 0; i < 16; i++)
         vecs.push_back('{i == 0, 1'b1, (i == 0) ? 8191 : 0, i[0], (i == 11) ? 4096 : 0});
      // Positive saturation window (trigger at j=23, x[k] = sample 23-k).
      for (int j = 0; j < 24; j++) begin
         k = 23 - j;
         vecs.push_back('{j == 0, 1'b1,
                          (k > 22) ? 0 : (h[k] > 0) ? 8191 : (h[k] < 0) ? -8192 : 0,
                          j == 23, 8191});
      end
      // Negated window.
      for (int j = 0; j < 24; j++) begin
         k = 23 - j;
         vecs.push_back('{j == 0, 1'b1,
                          (k > 22) ? 0 : (h[k] > 0) ? -8192 : (h[k] < 0) ? 8191 : 0,
                          j == 23, -8192});
      end

      #1;
      do_reset(5);
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset(5);
         apply(vecs[i].vld, vecs[i].din, vecs[i].has_exp, vecs[i].exp);
      end
      repeat (5) apply(0, 0, 0, 0);

      // DC: once the line is full every output is exactly 1000.
      do_reset(3);
      for (int i = 0; i < 40; i++) apply(1, 1000, i >= 22, 1000);
      repeat (5) apply(0, 0, 0, 0);

      // Odd impulse with in_valid every third cycle.
      do_reset(3);
      for (int i = 0; i < 26; i++) begin
         apply(1, (i == 1) ? 8191 : 0, i % 2 == 1,
               (i % 2 == 1 && (i - 1) / 2 < 12) ? odd_exp[(i - 1) / 2] : 0);
         apply(0, 0, 0, 0);
         apply(0, 0, 0, 0);
      end
      repeat (5) apply(0, 0, 0, 0);

      // Reset one cycle after a trigger: that result must never appear.
      do_reset(2);
      apply(1, 0, 0, 0);
      apply(1, 8191, 0, 0);
      dif.in_valid = 1'b0;
      @(posedge clk);
      #1;
      s0 = strobes;
      reset = 1'b1;
      model_clear();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("killed_trigger_strobes", strobes - s0, 0);
      // Phase restarts at 0 after release.
      apply(1, 8191, 0, 0);
      apply(1, 0, 0, 0);
      apply(1, 0, 0, 0);
      apply(1, 0, 0, 0);
      repeat (5) apply(0, 0, 0, 0);

      // Random stream with random gaps against the reference model.
      do_reset(3);
      for (int i = 0; i < 120; i++)
         apply(1'($urandom_range(0, 3) != 0), $urandom_range(0, 16383) - 8192, 0, 0);
      repeat (6) apply(0, 0, 0, 0);

      check("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
